// File: rtl/blockram_pkg.sv
// Shared types, constants and parameter helpers for the true dual-port
// byte-enable block RAM.
package blockram_pkg;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    localparam int READ_LAT_1 = 1;
    localparam int READ_LAT_2 = 2;

    function automatic int num_bytes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

    // True only for a word that splits evenly into lanes and a supported latency.
    function automatic bit params_ok(input int data_width, input int byte_width,
                                     input int read_latency);
        return (byte_width > 0) && (data_width >= byte_width) &&
               ((data_width % byte_width) == 0) &&
               ((read_latency == READ_LAT_1) || (read_latency == READ_LAT_2));
    endfunction

endpackage

// File: rtl/blockram_read_pipe.sv
// Delays a read result {data, valid} by STAGES extra registers; data only
// advances alongside a valid so the output holds its last read value.
module blockram_read_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  src_valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid
);

    if (STAGES == 0) begin : g_pass
        assign data  = src_data;
        assign valid = src_valid;
    end else begin : g_pipe
        logic [DATA_WIDTH-1:0] data_q [STAGES];
        logic [STAGES-1:0]     valid_q;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                valid_q <= '0;
                for (int s = 0; s < STAGES; s++) data_q[s] <= '0;
            end else begin
                valid_q[0] <= src_valid;
                if (src_valid) data_q[0] <= src_data;
                for (int s = 1; s < STAGES; s++) begin
                    valid_q[s] <= valid_q[s-1];
                    if (valid_q[s-1]) data_q[s] <= data_q[s-1];
                end
            end
        end

        assign data  = data_q[STAGES-1];
        assign valid = valid_q[STAGES-1];
    end

endmodule

// File: rtl/blockram_tdp_be_init.sv
// True dual-port block RAM with per-byte write enables, 1- or 2-cycle read
// latency, optional zero-clear after reset and a cross-port collision flag.
module blockram_tdp_be_init
    import blockram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                         CLK,
    input  logic                                         RST_N,
    input  logic                                         EN_A,
    input  logic                                         EN_B,
    input  logic [num_bytes(DATA_WIDTH, BYTE_WIDTH)-1:0] WE_A,
    input  logic [num_bytes(DATA_WIDTH, BYTE_WIDTH)-1:0] WE_B,
    input  logic [ADDR_WIDTH-1:0]                        ADDR_A,
    input  logic [ADDR_WIDTH-1:0]                        ADDR_B,
    input  logic [DATA_WIDTH-1:0]                        DI_A,
    input  logic [DATA_WIDTH-1:0]                        DI_B,
    output logic [DATA_WIDTH-1:0]                        DO_A,
    output logic [DATA_WIDTH-1:0]                        DO_B,
    output logic                                         DO_VALID_A,
    output logic                                         DO_VALID_B,
    output logic                                         READY,
    output logic                                         COLLISION
);

    localparam int                  NUM_BYTES   = num_bytes(DATA_WIDTH, BYTE_WIDTH);
    localparam int                  DEPTH       = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CLR_LAST    = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam state_t              RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    if (!params_ok(DATA_WIDTH, BYTE_WIDTH, READ_LATENCY)) begin : g_bad_params
        $error("blockram_tdp_be_init: illegal DATA_WIDTH/BYTE_WIDTH/READ_LATENCY");
    end

    state_t                state;
    logic [ADDR_WIDTH:0]   clr_cnt;
    logic                  ready;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  acc_a, acc_b, rd_a, rd_b, clearing;
    logic [NUM_BYTES-1:0]  wa_be, wb_be;
    logic [ADDR_WIDTH-1:0] wa_addr;
    logic [DATA_WIDTH-1:0] wa_data;

    logic [DATA_WIDTH-1:0] q_a, q_b;
    logic                  v_a, v_b, collision;

    assign clearing = (state == CLEAR);
    assign acc_a    = EN_A & ready;
    assign acc_b    = EN_B & ready;
    assign rd_a     = acc_a & ~(|WE_A);
    assign rd_b     = acc_b & ~(|WE_B);

    // The clear sequence borrows the port-A write path.
    assign wa_be    = clearing ? '1 : (acc_a ? WE_A : '0);
    assign wa_addr  = clearing ? clr_cnt[ADDR_WIDTH-1:0] : ADDR_A;
    assign wa_data  = clearing ? '0 : DI_A;
    assign wb_be    = acc_b ? WE_B : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= RESET_STATE;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == CLR_LAST) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: ready <= 1'b1;
                default: state <= RESET_STATE;
            endcase
        end
    end

    // NOTE: the array has no reset so it maps onto block RAM; zeroing is done
    // by the CLEAR sequence instead. Port B is written last so it wins a shared lane.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (wa_be[i]) mem[wa_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wa_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (wb_be[i]) mem[ADDR_B][i*BYTE_WIDTH +: BYTE_WIDTH]  <= DI_B[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // Reads sample the array before this edge's writes land, giving old data.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_a       <= '0;
            q_b       <= '0;
            v_a       <= 1'b0;
            v_b       <= 1'b0;
            collision <= 1'b0;
        end else begin
            v_a       <= rd_a;
            v_b       <= rd_b;
            if (rd_a) q_a <= mem[ADDR_A];
            if (rd_b) q_b <= mem[ADDR_B];
            collision <= acc_a & acc_b & (ADDR_A == ADDR_B) & ((|WE_A) | (|WE_B));
        end
    end

    blockram_read_pipe #(
        .DATA_WIDTH(DATA_WIDTH),
        .STAGES    (READ_LATENCY - 1)
    ) u_pipe_a (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .src_data (q_a),
        .src_valid(v_a),
        .data     (DO_A),
        .valid    (DO_VALID_A)
    );

    blockram_read_pipe #(
        .DATA_WIDTH(DATA_WIDTH),
        .STAGES    (READ_LATENCY - 1)
    ) u_pipe_b (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .src_data (q_b),
        .src_valid(v_b),
        .data     (DO_B),
        .valid    (DO_VALID_B)
    );

    assign READY     = ready;
    assign COLLISION = collision;

endmodule
